tattr_fill_engine: RTL and testbench
====================================

Name: tattr_fill_engine

Overview:
- Hardware fill/pattern engine for the video tile-attribute RAM write port. Writes up to TATTR_SIZE attribute bytes, one per cycle, so the CPU does not have to loop over store instructions.
- Arbitrates the single tattr write port between CPU stores and the engine. CPU always wins; the engine stalls for that cycle.
- Sits between the CPU bus decoder and the video unit's tattr port, in the CPU write-clock domain.

Parameters:
- ADDR_WIDTH, 9, tattr address width. TATTR_SIZE = 2**ADDR_WIDTH = 512.

Ports:
- clk  in  1  CPU/write clock.
- rst_n  in  1  async active-low reset.
- cfg_addr  in  2  register select: 0 DST, 1 LEN, 2 PATTERN, 3 CTRL/STATUS.
- cfg_wdata  in  16  register write data.
- cfg_wenable  in  1  register write strobe.
- cfg_rdata  out  16  register read data, combinational from cfg_addr.
- cpu_tattr_addr  in  ADDR_WIDTH  CPU tattr address.
- cpu_tattr_wdata  in  8  CPU tattr write data.
- cpu_tattr_wenable  in  1  CPU tattr write strobe.
- tattr_addr  out  ADDR_WIDTH  to the video unit's tattr port.
- tattr_wdata  out  8  to the video unit's tattr port.
- tattr_wenable  out  1  to the video unit's tattr port.
- vblank  in  1  high outside the visible area, synchronous to clk.
- busy  out  1  high while state != IDLE.
- irq  out  1  irq_pending & irq_en.

Behaviour:
- Registers:
  - DST[ADDR_WIDTH-1:0]: start address.
  - LEN[ADDR_WIDTH:0]: byte count, 0..512; written values >512 saturate to 512.
  - PATTERN: [7:0] VALUE, [15:8] INC.
  - CTRL write bits: bit0 START, bit1 irq_en (stored), bit2 IRQ_CLR (write-1), bit3 ABORT (write-1).
  - STATUS read bits: bit0 busy, bit1 irq_pending, bit2 irq_en; other bits 0.
- Reset: state IDLE, DST=0, LEN=0, PATTERN=0, irq_en=0, irq_pending=0, busy=0, irq=0, tattr_wenable=0.
- Writes to DST, LEN and PATTERN while busy are ignored. Reads are always valid.
- FSM states: IDLE, WAIT_VB, FILL, DONE.
  - IDLE -> START: cur_addr<=DST, remaining<=LEN, cur_val<=VALUE. Next state is WAIT_VB if FILL_VBLANK_SYNC_EN is defined, else FILL. Latency: START written in cycle T; first engine write is possible in cycle T+1.
  - IDLE with START and LEN=0: go to DONE, perform no writes.
  - START while busy is ignored.
  - FILL: a write is granted when cpu_tattr_wenable=0 and no pause condition holds (see Optional Feature). Each granted cycle writes cur_val at cur_addr. Then cur_addr+1 wraps modulo TATTR_SIZE (511 -> 0), cur_val+INC wraps modulo 256, remaining-1. A granted write with remaining=1 goes to DONE.
  - DONE: set irq_pending; go to IDLE next cycle. busy is high for the single DONE cycle.
  - ABORT in any busy state: IDLE next cycle, irq_pending unchanged, no further engine writes. A granted write in the abort cycle still completes.
  - IRQ_CLR clears irq_pending. If it coincides with DONE setting it, set wins.
- Port mux (combinational):
  - cpu_tattr_wenable=1: outputs = CPU addr/data, wenable=1.
  - Else if a write is granted: outputs = cur_addr/cur_val, wenable=1.
  - Else: outputs = CPU addr/data, wenable=0.
- CPU reads of tattr_rdata are valid only when busy=0 or in CPU-write cycles.
- Async reset mid-fill: immediate return to reset values. The partial fill is left in RAM.

Optional Feature:
- Macro FILL_VBLANK_SYNC_EN.
- Defined:
  - START enters WAIT_VB, which holds until vblank=1, then goes to FILL.
  - In FILL, vblank=0 pauses: no write, no counter change; resumes when vblank=1. This keeps RAM updates out of the visible area.
  - ABORT from WAIT_VB -> IDLE.
- Not defined: WAIT_VB is unreachable, vblank is ignored, FILL writes every free cycle.

Test Plan:
- DST=10, LEN=4, VALUE=0x20, INC=1, START -> tattr writes (10,0x20),(11,0x21),(12,0x22),(13,0x23) on 4 consecutive cycles; busy high 5 cycles; irq_pending=1; irq=0 while irq_en=0.
- DST=510, LEN=3, VALUE=0xFF, INC=2 -> writes (510,0xFF),(511,0x01),(0,0x03); wrap on both fields.
- CPU write (100,0xAA) during 2nd cycle of a LEN=4 fill at DST=0 -> that cycle outputs (100,0xAA). Engine writes addresses 0,1,2,3, finishing one cycle later; no address is skipped.
- LEN=0 with irq_en=1, START -> no tattr_wenable; irq=1 two cycles after START. IRQ_CLR -> irq=0.
- LEN=8 fill, ABORT after 3 writes -> exactly 3 writes; busy=0 next cycle; irq_pending stays 0. Writing DST mid-fill leaves DST unchanged.
- FILL_VBLANK_SYNC_EN defined, vblank=0, LEN=2, START -> no writes until vblank rises. vblank drops after the first write -> second write only after vblank returns high.

Source files
------------

// File: rtl/tattr_fill_engine.sv
// ----------------------------------------------------------------------------
// tattr_fill_engine
//
// Purpose:
//   Hardware fill/pattern engine for the video tile-attribute (tattr) RAM
//   write port. Once started, it writes up to 2**ADDR_WIDTH attribute bytes,
//   one per cycle. Each byte is the current value, and the value advances by
//   a programmable increment after every write. The block also arbitrates
//   the single tattr write port between CPU stores and the engine. A CPU
//   store always wins, and the engine simply stalls for that cycle.
//
// Optional build macro:
//   FILL_VBLANK_SYNC_EN - when defined, a fill first waits for vblank=1.
//   It then writes only while vblank=1, so RAM updates stay out of the
//   visible area. When undefined, vblank is ignored.
//
// Ports:
//   clk, rst_n          CPU/write clock, async active-low reset
//   cfg_addr            register select: 0 DST, 1 LEN, 2 PATTERN, 3 CTRL/STATUS
//   cfg_wdata           register write data
//   cfg_wenable         register write strobe
//   cfg_rdata           register read data (combinational from cfg_addr)
//   cpu_tattr_*         CPU tattr store (addr / data / write strobe)
//   tattr_*             muxed tattr write port toward the video unit
//   vblank              high outside the visible area (clk domain)
//   busy                high while the engine is not IDLE
//   irq                 irq_pending & irq_en
//   dbg_state           current FSM state (IDLE=0, WAIT_VB=1, FILL=2, DONE=3)
//
// Strobe semantics:
//   cfg_wenable and cpu_tattr_wenable are single-cycle strobes. Each strobe
//   is accepted in the cycle it is high, and neither side has a ready/back-
//   pressure signal. When the engine loses arbitration it holds all of its
//   counters, so a CPU store never causes a fill byte to be skipped.
// ----------------------------------------------------------------------------
module tattr_fill_engine #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            cfg_addr,
    input  logic [15:0]           cfg_wdata,
    input  logic                  cfg_wenable,
    output logic [15:0]           cfg_rdata,
    input  logic [ADDR_WIDTH-1:0] cpu_tattr_addr,
    input  logic [7:0]            cpu_tattr_wdata,
    input  logic                  cpu_tattr_wenable,
    output logic [ADDR_WIDTH-1:0] tattr_addr,
    output logic [7:0]            tattr_wdata,
    output logic                  tattr_wenable,
    input  logic                  vblank,
    output logic                  busy,
    output logic                  irq,
    output logic [1:0]            dbg_state
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    // The largest legal byte count is the full RAM size.
    localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [15:0] LEN_MAX_16 = {{(16-LEN_W){1'b0}}, LEN_MAX};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [15:0]            pattern_q, pattern_d;
    logic                   irq_en_q, irq_en_d;
    logic                   irq_pending_q, irq_pending_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]       remaining_q, remaining_d;
    logic [7:0]             cur_val_q, cur_val_d;

    logic ctrl_wr;
    logic start;
    logic abort;
    logic irq_clr;
    logic irq_set;
    logic busy_int;
    logic fill_ok;
    logic grant;

    always_comb begin
        ctrl_wr  = cfg_wenable && (cfg_addr == 2'd3);
        start    = ctrl_wr && cfg_wdata[0];
        irq_clr  = ctrl_wr && cfg_wdata[2];
        abort    = ctrl_wr && cfg_wdata[3];
        busy_int = (state_q != IDLE);
`ifdef FILL_VBLANK_SYNC_EN
        fill_ok  = vblank;
`else
        // vblank has no effect in this build, so the OR folds to a constant 1.
        fill_ok  = vblank | 1'b1;
`endif
        grant    = (state_q == FILL) && !cpu_tattr_wenable && fill_ok;
    end

    // Next-state / datapath
    always_comb begin
        state_d       = state_q;
        dst_d         = dst_q;
        len_d         = len_q;
        pattern_d     = pattern_q;
        irq_en_d      = irq_en_q;
        irq_pending_d = irq_pending_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        cur_val_d     = cur_val_q;
        irq_set       = 1'b0;

        // The configuration registers are frozen while a fill is in progress.
        if (cfg_wenable && !busy_int) begin
            case (cfg_addr)
                2'd0: dst_d = cfg_wdata[ADDR_WIDTH-1:0];
                2'd1: len_d = (cfg_wdata > LEN_MAX_16) ? LEN_MAX
                                                      : cfg_wdata[LEN_W-1:0];
                2'd2: pattern_d = cfg_wdata;
                default: ;
            endcase
        end
        if (ctrl_wr) begin
            irq_en_d = cfg_wdata[1];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = dst_q;
                    remaining_d = len_q;
                    cur_val_d   = pattern_q[7:0];
                    if (len_q == '0) begin
                        state_d = DONE;
                    end else begin
`ifdef FILL_VBLANK_SYNC_EN
                        state_d = WAIT_VB;
`else
                        state_d = FILL;
`endif
                    end
                end
            end
            WAIT_VB: begin
`ifdef FILL_VBLANK_SYNC_EN
                if (vblank) begin
                    state_d = FILL;
                end
`else
                state_d = IDLE;
`endif
            end
            FILL: begin
                if (grant) begin
                    // The address and value both wrap naturally at their
                    // own widths.
                    cur_addr_d  = cur_addr_q + 1'b1;
                    cur_val_d   = cur_val_q + pattern_q[15:8];
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                irq_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // ABORT overrides every busy state. A write already granted in this
        // cycle still reaches the port, because the mux below uses grant.
        if (abort && busy_int) begin
            state_d = IDLE;
            irq_set = 1'b0;
        end

        // If a set and a clear arrive in the same cycle, the set wins.
        if (irq_set) begin
            irq_pending_d = 1'b1;
        end else if (irq_clr) begin
            irq_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dst_q         <= '0;
            len_q         <= '0;
            pattern_q     <= '0;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            cur_val_q     <= '0;
        end else begin
            state_q       <= state_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            pattern_q     <= pattern_d;
            irq_en_q      <= irq_en_d;
            irq_pending_q <= irq_pending_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            cur_val_q     <= cur_val_d;
        end
    end

    // Port mux: a CPU store wins, then an engine write, otherwise idle.
    always_comb begin
        tattr_addr    = cpu_tattr_addr;
        tattr_wdata   = cpu_tattr_wdata;
        tattr_wenable = 1'b0;
        if (cpu_tattr_wenable) begin
            tattr_wenable = 1'b1;
        end else if (grant) begin
            tattr_addr    = cur_addr_q;
            tattr_wdata   = cur_val_q;
            tattr_wenable = 1'b1;
        end
    end

    always_comb begin
        cfg_rdata = 16'h0000;
        case (cfg_addr)
            2'd0: cfg_rdata = 16'(dst_q);
            2'd1: cfg_rdata = 16'(len_q);
            2'd2: cfg_rdata = pattern_q;
            default: cfg_rdata = {13'd0, irq_en_q, irq_pending_q, busy_int};
        endcase
    end

    assign busy      = busy_int;
    assign irq       = irq_pending_q & irq_en_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tattr_fill_engine.sv
// ----------------------------------------------------------------------------
// tb_tattr_fill_engine
//
// Directed bench for tattr_fill_engine. A negedge monitor records every
// tattr write as (addr, data, cycle). Each scenario then compares the
// recorded writes, busy, irq and the register read-back against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_tattr_fill_engine;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_wenable;
    logic [15:0] cfg_rdata;
    logic [8:0]  cpu_tattr_addr;
    logic [7:0]  cpu_tattr_wdata;
    logic        cpu_tattr_wenable;
    logic [8:0]  tattr_addr;
    logic [7:0]  tattr_wdata;
    logic        tattr_wenable;
    logic        vblank;
    logic        busy;
    logic        irq;
    logic [1:0]  dbg_state;

    tattr_fill_engine #(.ADDR_WIDTH(9)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_addr          (cfg_addr),
        .cfg_wdata         (cfg_wdata),
        .cfg_wenable       (cfg_wenable),
        .cfg_rdata         (cfg_rdata),
        .cpu_tattr_addr    (cpu_tattr_addr),
        .cpu_tattr_wdata   (cpu_tattr_wdata),
        .cpu_tattr_wenable (cpu_tattr_wenable),
        .tattr_addr        (tattr_addr),
        .tattr_wdata       (tattr_wdata),
        .tattr_wenable     (tattr_wenable),
        .vblank            (vblank),
        .busy              (busy),
        .irq               (irq),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- write monitor ----------------
    logic [8:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];

    always @(negedge clk) begin
        if (tattr_wenable) begin
            wr_addr_q.push_back(tattr_addr);
            wr_data_q.push_back(tattr_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input int i, input logic [8:0] a, input logic [7:0] d, input int c);
        if (i < wr_addr_q.size()) begin
            check_eq($sformatf("wr%0d_addr", i), 32'(wr_addr_q[i]), 32'(a));
            check_eq($sformatf("wr%0d_data", i), 32'(wr_data_q[i]), 32'(d));
            check_eq($sformatf("wr%0d_cycle", i), wr_cyc_q[i], c);
        end else begin
            check_eq($sformatf("wr%0d_present", i), 32'd0, 32'd1);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        busy_cnt = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Drives one register write during the cycle that starts at the next
    // posedge. s returns that cycle's index. The task returns 1 ns into
    // cycle s+1.
    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d, output int s);
        @(posedge clk);
        #1;
        s           = cyc;
        cfg_addr    = a;
        cfg_wdata   = d;
        cfg_wenable = 1'b1;
        @(posedge clk);
        #1;
        cfg_wenable = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
        cfg_addr = a;
        #1;
        check_eq(tag, 32'(cfg_rdata), 32'(exp));
    endtask

    task automatic tick_count(input int n);
        repeat (n) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
    endtask

    int s;
    int d;

    initial begin
        rst_n             = 1'b0;
        cfg_addr          = 2'd0;
        cfg_wdata         = 16'h0;
        cfg_wenable       = 1'b0;
        cpu_tattr_addr    = 9'd0;
        cpu_tattr_wdata   = 8'd0;
        cpu_tattr_wenable = 1'b0;
        vblank            = 1'b1;
        busy_cnt          = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- reset state ----
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_wen", 32'(tattr_wenable), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rd_check("rst_dst", 2'd0, 16'h0000);
        rd_check("rst_len", 2'd1, 16'h0000);
        rd_check("rst_pattern", 2'd2, 16'h0000);
        rd_check("rst_status", 2'd3, 16'h0000);

        // ---- LEN saturation ----
        cfg_write(2'd1, 16'h0401, d);
        rd_check("len_sat_1025", 2'd1, 16'h0200);
        cfg_write(2'd1, 16'h0200, d);
        rd_check("len_512", 2'd1, 16'h0200);
        cfg_write(2'd1, 16'h01FF, d);
        rd_check("len_511", 2'd1, 16'h01FF);

        // ---- basic fill: DST=10 LEN=4 VALUE=0x20 INC=1 ----
        cfg_write(2'd0, 16'd10, d);
        cfg_write(2'd1, 16'd4, d);
        cfg_write(2'd2, 16'h0120, d);
        clear_log();
        cfg_write(2'd3, 16'h0001, s);
        tick_count(8);
        check_eq("t1_nwr", wr_addr_q.size(), 4);
        check_wr(0, 9'd10, 8'h20, s + 1);
        check_wr(1, 9'd11, 8'h21, s + 2);
        check_wr(2, 9'd12, 8'h22, s + 3);
        check_wr(3, 9'd13, 8'h23, s + 4);
        check_eq("t1_busy_cycles", busy_cnt, 5);
        check_eq("t1_irq", 32'(irq), 32'd0);
        rd_check("t1_status", 2'd3, 16'h0002);
        cfg_write(2'd3, 16'h0004, d);
        rd_check("t1_status_clr", 2'd3, 16'h0000);

        // ---- wrap: DST=510 LEN=3 VALUE=0xFF INC=2 ----
        cfg_write(2'd0, 16'd510, d);
        cfg_write(2'd1, 16'd3, d);
        cfg_write(2'd2, 16'h02FF, d);
        clear_log();
        cfg_write(2'd3, 16'h0001, s);
        tick_count(6);
        check_eq("t2_nwr", wr_addr_q.size(), 3);
        check_wr(0, 9'd510, 8'hFF, s + 1);
        check_wr(1, 9'd511, 8'h01, s + 2);
        check_wr(2, 9'd0, 8'h03, s + 3);
        check_eq("t2_busy_cycles", busy_cnt, 4);
        cfg_write(2'd3, 16'h0004, d);

        // ---- CPU store in 2nd fill cycle: DST=0 LEN=4 VALUE=0x10 INC=1 ----
        cfg_write(2'd0, 16'd0, d);
        cfg_write(2'd1, 16'd4, d);
        cfg_write(2'd2, 16'h0110, d);
        clear_log();
        cfg_write(2'd3, 16'h0001, s);
        tick_count(1);
        @(posedge clk);
        #1;
        cpu_tattr_addr    = 9'd100;
        cpu_tattr_wdata   = 8'hAA;
        cpu_tattr_wenable = 1'b1;
        tick_count(1);
        @(posedge clk);
        #1;
        cpu_tattr_wenable = 1'b0;
        tick_count(6);
        check_eq("t3_nwr", wr_addr_q.size(), 5);
        check_wr(0, 9'd0, 8'h10, s + 1);
        check_wr(1, 9'd100, 8'hAA, s + 2);
        check_wr(2, 9'd1, 8'h11, s + 3);
        check_wr(3, 9'd2, 8'h12, s + 4);
        check_wr(4, 9'd3, 8'h13, s + 5);
        check_eq("t3_busy_cycles", busy_cnt, 6);
        cfg_write(2'd3, 16'h0004, d);

        // ---- LEN=0 with irq_en ----
        cfg_write(2'd1, 16'd0, d);
        cfg_write(2'd3, 16'h0002, d);
        rd_check("t4_status_en", 2'd3, 16'h0004);
        clear_log();
        cfg_write(2'd3, 16'h0003, s);
        @(negedge clk);
        check_eq("t4_done_busy", 32'(busy), 32'd1);
        check_eq("t4_done_state", 32'(dbg_state), 32'd3);
        check_eq("t4_irq_early", 32'(irq), 32'd0);
        @(negedge clk);
        check_eq("t4_irq", 32'(irq), 32'd1);
        check_eq("t4_idle_busy", 32'(busy), 32'd0);
        check_eq("t4_nwr", wr_addr_q.size(), 0);
        cfg_write(2'd3, 16'h0006, d);
        check_eq("t4_irq_clr", 32'(irq), 32'd0);
        cfg_write(2'd3, 16'h0000, d);

        // ---- ABORT after 3 writes; DST write mid-fill ignored ----
        cfg_write(2'd0, 16'd20, d);
        cfg_write(2'd1, 16'd8, d);
        cfg_write(2'd2, 16'h0130, d);
        clear_log();
        cfg_write(2'd3, 16'h0001, s);
        cfg_addr    = 2'd0;
        cfg_wdata   = 16'h0055;
        cfg_wenable = 1'b1;
        @(posedge clk);
        #1;
        cfg_wenable = 1'b0;
        @(posedge clk);
        #1;
        cfg_addr    = 2'd3;
        cfg_wdata   = 16'h0008;
        cfg_wenable = 1'b1;
        @(posedge clk);
        #1;
        cfg_wenable = 1'b0;
        @(negedge clk);
        check_eq("t5_busy_after_abort", 32'(busy), 32'd0);
        tick_count(4);
        check_eq("t5_nwr", wr_addr_q.size(), 3);
        check_wr(0, 9'd20, 8'h30, s + 1);
        check_wr(1, 9'd21, 8'h31, s + 2);
        check_wr(2, 9'd22, 8'h32, s + 3);
        rd_check("t5_status", 2'd3, 16'h0000);
        rd_check("t5_dst", 2'd0, 16'd20);

        // ---- vblank behaviour: DST=40 LEN=2 VALUE=0x05 INC=1 ----
        cfg_write(2'd0, 16'd40, d);
        cfg_write(2'd1, 16'd2, d);
        cfg_write(2'd2, 16'h0105, d);
        vblank = 1'b0;
        clear_log();
        cfg_write(2'd3, 16'h0001, s);
`ifdef FILL_VBLANK_SYNC_EN
        tick_count(3);
        check_eq("t6_nwr_wait", wr_addr_q.size(), 0);
        check_eq("t6_wait_state", 32'(dbg_state), 32'd1);
        @(posedge clk);
        #1;
        vblank = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        vblank = 1'b0;
        @(posedge clk);
        #1;
        vblank = 1'b1;
        tick_count(4);
        check_eq("t6_nwr", wr_addr_q.size(), 2);
        check_wr(0, 9'd40, 8'h05, s + 5);
        check_wr(1, 9'd41, 8'h06, s + 7);
`else
        tick_count(4);
        check_eq("t6_nwr", wr_addr_q.size(), 2);
        check_wr(0, 9'd40, 8'h05, s + 1);
        check_wr(1, 9'd41, 8'h06, s + 2);
        vblank = 1'b1;
`endif
        cfg_write(2'd3, 16'h0004, d);

        // ---- async reset mid-fill ----
        cfg_write(2'd1, 16'd8, d);
        cfg_write(2'd3, 16'h0003, s);
        tick_count(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t7_rst_busy", 32'(busy), 32'd0);
        check_eq("t7_rst_wen", 32'(tattr_wenable), 32'd0);
        check_eq("t7_rst_state", 32'(dbg_state), 32'd0);
        rd_check("t7_rst_dst", 2'd0, 16'h0000);
        rd_check("t7_rst_status", 2'd3, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
